// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - register-mapped UART transmitter with byte FIFO and drain interrupt
// Optional parity stage: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int          DEPTH       = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq,
    output logic        uart_txd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf, r_irq_en, r_irq, r_txd, r_par;
    logic [15:0]   r_div, r_frame_div, r_bitcnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitidx;

    logic          w_empty, w_full, w_busy, w_last, w_push, w_pop, w_accept;
    logic          w_ctrl_wr, w_irq_en_nxt, w_odd, w_unused;
    logic [15:0]   w_div_eff;
    logic [7:0]    w_head;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_busy       = (r_state != S_IDLE);
    assign w_last       = (r_bitcnt == r_frame_div - 16'd1);
    assign w_push       = write_enable && (addr == 2'd0);
    assign w_ctrl_wr    = write_enable && (addr == 2'd2);
    // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
    assign w_pop        = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));
    assign w_accept     = w_push && (!w_full || w_pop);
    assign w_irq_en_nxt = w_ctrl_wr ? write_data[0] : r_irq_en;
    assign w_div_eff    = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_head       = r_mem[r_rptr];
    assign w_unused     = ^{write_data[31:16], write_data[2], r_par};

`ifdef UART_TX_PARITY_EN
    logic r_odd;
    always_ff @(posedge clk) begin
        if (rst)            r_odd <= 1'b0;
        else if (w_ctrl_wr) r_odd <= write_data[2];
    end
    assign w_odd = r_odd;
`else
    assign w_odd = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_div    <= DEFAULT_DIV;
            r_irq    <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_pop};
            if (w_push && !w_accept)           r_ovf <= 1'b1;
            else if (w_ctrl_wr && write_data[1]) r_ovf <= 1'b0;
            r_irq_en <= w_irq_en_nxt;
            if (write_enable && (addr == 2'd3)) r_div <= write_data[15:0];
            r_irq <= w_irq_en_nxt && w_empty && !w_busy && !w_push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_txd       <= 1'b1;
            r_bitcnt    <= 16'd0;
            r_bitidx    <= 3'd0;
            r_shift     <= 8'd0;
            r_par       <= 1'b0;
            r_frame_div <= 16'd1;
        end else begin
            case (r_state)
                S_IDLE, S_STOP: begin
                    if (r_state == S_STOP && !w_last) begin
                        r_bitcnt <= r_bitcnt + 16'd1;
                    end else if (w_pop) begin
                        // Divider is frozen per frame so mid-frame DIV writes take effect next frame.
                        r_shift     <= w_head;
                        r_par       <= (^w_head) ^ w_odd;
                        r_frame_div <= w_div_eff;
                        r_bitcnt    <= 16'd0;
                        r_txd       <= 1'b0;
                        r_state     <= S_START;
                    end else begin
                        r_bitcnt <= 16'd0;
                        r_txd    <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_last) begin
                        r_bitcnt <= 16'd0;
                        r_bitidx <= 3'd0;
                        r_txd    <= r_shift[0];
                        r_state  <= S_DATA;
                    end else begin
                        r_bitcnt <= r_bitcnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (!w_last) begin
                        r_bitcnt <= r_bitcnt + 16'd1;
                    end else if (r_bitidx == 3'd7) begin
                        r_bitcnt <= 16'd0;
`ifdef UART_TX_PARITY_EN
                        r_txd    <= r_par;
                        r_state  <= S_PARITY;
`else
                        r_txd    <= 1'b1;
                        r_state  <= S_STOP;
`endif
                    end else begin
                        r_bitcnt <= 16'd0;
                        r_bitidx <= r_bitidx + 3'd1;
                        r_shift  <= r_shift >> 1;
                        r_txd    <= r_shift[1];
                    end
                end
                S_PARITY: begin
                    if (w_last) begin
                        r_bitcnt <= 16'd0;
                        r_txd    <= 1'b1;
                        r_state  <= S_STOP;
                    end else begin
                        r_bitcnt <= r_bitcnt + 16'd1;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        read_result = 32'd0;
        case (addr)
            2'd1:    read_result = {20'd0, r_ovf, w_busy, w_full, w_empty, 8'(r_count)};
            2'd2:    read_result = {29'd0, w_odd, 1'b0, r_irq_en};
            2'd3:    read_result = {16'd0, r_div};
            default: read_result = 32'd0;
        endcase
    end

    assign irq      = r_irq;
    assign uart_txd = r_txd;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo with a serial line monitor
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = 2'd1;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_result;
    logic        irq;
    logic        uart_txd;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .write_data(write_data), .read_result(read_result), .irq(irq), .uart_txd(uart_txd)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: bytes queued but not yet started, plus register contents.
    logic [7:0] q[$];
    bit  m_ovf = 0, m_irq_en = 0, m_odd = 0;
    int  m_div = 434;
    bit  mon_en = 1, in_frame = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; write_enable = 1'b1; write_data = d;
        @(posedge clk);
        case (a)
            2'd0: if (q.size() < DEPTH) q.push_back(d[7:0]); else m_ovf = 1;
            2'd2: begin
                m_irq_en = d[0];
                if (d[1]) m_ovf = 0;
`ifdef UART_TX_PARITY_EN
                m_odd = d[2];
`endif
            end
            2'd3: m_div = int'(d[15:0]);
            default: ;
        endcase
        #1;
        write_enable = 1'b0; addr = 2'd1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = read_result;
        addr = 2'd1;
    endtask

    function automatic logic [31:0] stat_exp(input bit busy);
        return {20'd0, m_ovf, busy, q.size() == DEPTH, q.size() == 0, 8'(q.size())};
    endfunction

    task automatic run_frame();
        logic [7:0] b;
        logic       lv [11];
        int         d;
        bit         more;
        more = 1;
        in_frame = 1;
        while (more) begin
            check_eq("frame_has_byte", 32'(q.size() != 0), 32'd1);
            if (q.size() == 0) begin
                in_frame = 0;
                return;
            end
            b = q.pop_front();
            d = (m_div == 0) ? 1 : m_div;
            if (addr == 2'd1 && !write_enable)
                check_eq("stat_count_at_pop", read_result[7:0], 32'(q.size()));
            lv[0] = 1'b0;
            for (int i = 0; i < 8; i++) lv[i+1] = b[i];
            lv[9] = (^b) ^ m_odd;
            lv[NB-1] = 1'b1;
            for (int bi = 0; bi < NB; bi++) begin
                for (int c = 0; c < d; c++) begin
                    if (bi != 0 || c != 0) @(negedge clk);
                    check_eq($sformatf("txd_bit%0d", bi), 32'(uart_txd), 32'(lv[bi]));
                end
            end
            @(negedge clk);
            if (q.size() != 0) begin
                check_eq("no_gap", 32'(uart_txd), 32'd0);
            end else begin
                check_eq("idle_after_stop", 32'(uart_txd), 32'd1);
                more = 0;
            end
        end
        in_frame = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && uart_txd === 1'b0) run_frame();
        end
    end

    task automatic wait_idle(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (q.size() == 0 && !in_frame) break;
            tick();
        end
        check_eq("idle_reached", 32'(q.size() == 0 && !in_frame), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int n;

        repeat (3) tick();
        check_eq("rst_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        rd(2'd1, v); check_eq("rst_stat", v, 32'h100);
        rd(2'd2, v); check_eq("rst_ctrl", v, 32'd0);
        rd(2'd3, v); check_eq("rst_div", v, 32'd434);
        rst = 1'b0;
        tick();

        wr(2'd3, 32'd4);
        wr(2'd0, 32'hA5);
        check_eq("latency_e0", 32'(uart_txd), 32'd1);
        tick();
        check_eq("latency_e1", 32'(uart_txd), 32'd0);
        wait_idle(200);

        wr(2'd3, 32'd2);
        repeat (3) wr(2'd0, $urandom);
        wait_idle(300);

        wr(2'd3, 32'd4);
        wr(2'd2, 32'd1);
        check_eq("irq_idle", 32'(irq), 32'd1);
        wr(2'd0, 32'h3C);
        check_eq("irq_push_clear", 32'(irq), 32'd0);
        for (int k = 1; k <= NB*4 + 2; k++) begin
            tick();
            check_eq($sformatf("irq_k%0d", k), 32'(irq), 32'(k == NB*4 + 2));
        end
        wr(2'd2, 32'd0);
        check_eq("irq_en_clear", 32'(irq), 32'd0);

        wr(2'd3, 32'd4);
        wr(2'd0, $urandom);
        wr(2'd0, $urandom);
        repeat (10) tick();
        wr(2'd3, 32'd8);
        wait_idle(500);

        wr(2'd3, 32'd0);
        wr(2'd0, $urandom);
        wait_idle(100);

        wr(2'd2, 32'd7);
        rd(2'd2, v); check_eq("ctrl_rb", v, {29'd0, m_odd, 1'b0, m_irq_en});
        wr(2'd2, 32'd0);

        wr(2'd3, 32'd8);
        wr(2'd0, $urandom);
        repeat (3) tick();
        repeat (DEPTH + 1) wr(2'd0, $urandom);
        rd(2'd1, v); check_eq("stat_full_ovf", v, stat_exp(1'b1));
        wr(2'd2, 32'd2);
        rd(2'd1, v); check_eq("stat_ovf_clr", v, stat_exp(1'b1));
        wait_idle(3000);
        repeat (30) tick();
        check_eq("quiet_after_drain", 32'(uart_txd), 32'd1);
        rd(2'd1, v); check_eq("stat_drained", v, 32'h100);

        for (int it = 0; it < 20; it++) begin
            wr(2'd3, $urandom_range(0, 5));
            n = $urandom_range(1, 5);
            repeat (n) wr(2'd0, $urandom);
            wait_idle(500);
        end

`ifdef UART_TX_PARITY_EN
        wr(2'd3, 32'd2);
        wr(2'd0, 32'h07);
        wait_idle(100);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h07);
        wait_idle(100);
        wr(2'd2, 32'd0);
`endif

        mon_en = 0;
        wr(2'd3, 32'd4);
        wr(2'd0, 32'h00);
        wr(2'd0, 32'h55);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_txd", 32'(uart_txd), 32'd1);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        rd(2'd1, v); check_eq("midrst_stat", v, 32'h100);
        rd(2'd3, v); check_eq("midrst_div", v, 32'd434);
        rst = 1'b0;
        q.delete();
        m_ovf = 0; m_irq_en = 0; m_odd = 0; m_div = 434;
        n = 0;
        repeat (60) begin
            tick();
            if (uart_txd !== 1'b1) n++;
        end
        check_eq("midrst_no_resume", 32'(n), 32'd0);
        mon_en = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
